// File: rtl/adc_cap_pkg.sv
// Shared types and defaults for the ADC pre/post-trigger capture controller.
package adc_cap_pkg;

   localparam int ADC_W_DEF  = 12;
   localparam int ADDR_W_DEF = 10;
   localparam int RAM_W      = 16;

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      WAIT_TRIG,
      POST,
      DONE
   } cap_state_e;

endpackage

// File: rtl/adc_trig_detect.sv
// Level/slope trigger detector over decimated samples; remembers the previous
// strobed sample and flags a threshold crossing in the selected direction.
module adc_trig_detect
   import adc_cap_pkg::*;
#(
   parameter int ADC_W = ADC_W_DEF
) (
   input  logic             sys_clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic [ADC_W-1:0] i_cur,
   input  logic [ADC_W-1:0] i_level,
   input  logic             i_rising,
   output logic             o_hit
);

   logic [ADC_W-1:0] r_prev;
   logic             r_prev_vld;
   logic             w_rise;
   logic             w_fall;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev     <= '0;
         r_prev_vld <= 1'b0;
      end else if (i_clr) begin
         r_prev_vld <= 1'b0;
      end else if (i_en) begin
         r_prev     <= i_cur;
         r_prev_vld <= 1'b1;
      end
   end

   assign w_rise = (r_prev < i_level) && (i_cur >= i_level);
   assign w_fall = (r_prev > i_level) && (i_cur <= i_level);
   assign o_hit  = r_prev_vld && (i_rising ? w_rise : w_fall);

endmodule

// File: rtl/adc_capture_ctrl.sv
// Pre/post-trigger capture controller feeding a 2**ADDR_W x 16 sample RAM.
// Define AUTO_TRIG_EN to force a trigger after TIMEOUT cycles in WAIT_TRIG.
module adc_capture_ctrl
   import adc_cap_pkg::*;
#(
   parameter int ADC_W     = ADC_W_DEF,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int PRE_DEPTH = 256,
   parameter int TIMEOUT   = 2**20
) (
   input  logic              sys_clk,
   input  logic              rst_n,
   input  logic [ADC_W-1:0]  adc_data,
   input  logic              arm,
   input  logic              abort,
   input  logic [ADC_W-1:0]  trig_level,
   input  logic              trig_rising,
   input  logic [7:0]        decim,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [RAM_W-1:0]  wr_data,
   output logic [ADDR_W-1:0] trig_addr,
   output logic              busy,
   output logic              done,
   output logic              forced
);

   localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_DEPTH - 1);
   localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(2**ADDR_W - PRE_DEPTH - 2);

   cap_state_e        r_state;
   logic [ADC_W-1:0]  r_sample;
   logic [7:0]        r_dcnt;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W-1:0] r_cnt;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [RAM_W-1:0]  r_wr_data;
   logic [ADDR_W-1:0] r_trig_addr;
   logic              r_busy;
   logic              r_done;
   logic              r_forced;

   logic w_strobe;
   logic w_arm_ok;
   logic w_capturing;
   logic w_hit;
   logic w_timed_out;
   logic w_trig;

   assign w_strobe    = (r_dcnt == 8'd0);
   assign w_arm_ok    = arm && !abort && (r_state == IDLE);
   assign w_capturing = (r_state == PRE) || (r_state == WAIT_TRIG) || (r_state == POST);
   assign w_trig      = w_hit || w_timed_out;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) r_sample <= '0;
      else        r_sample <= adc_data;
   end

   // Free-running decimator; arm realigns it so the first sample is kept.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n)                r_dcnt <= 8'd0;
      else if (w_arm_ok)         r_dcnt <= 8'd0;
      else if (r_dcnt >= decim)  r_dcnt <= 8'd0;
      else                       r_dcnt <= r_dcnt + 8'd1;
   end

   adc_trig_detect #(.ADC_W(ADC_W)) u_trig (
      .sys_clk  (sys_clk),
      .rst_n    (rst_n),
      .i_clr    (w_arm_ok),
      .i_en     (w_strobe && w_capturing),
      .i_cur    (r_sample),
      .i_level  (trig_level),
      .i_rising (trig_rising),
      .o_hit    (w_hit)
   );

`ifdef AUTO_TRIG_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0] r_tcnt;

   // Counts cycles spent in WAIT_TRIG and saturates; any exit discards it.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n)                    r_tcnt <= '0;
      else if (r_state != WAIT_TRIG) r_tcnt <= '0;
      else if (!w_timed_out)         r_tcnt <= r_tcnt + TO_W'(1);
   end

   assign w_timed_out = (r_tcnt == TO_W'(TIMEOUT));
`else
   assign w_timed_out = 1'b0;
`endif

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_cnt       <= '0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_trig_addr <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_forced    <= 1'b0;
      end else begin
         r_wr_en <= 1'b0;
         r_done  <= 1'b0;
         if (abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (arm) begin
                     r_state  <= PRE;
                     r_ptr    <= '0;
                     r_cnt    <= '0;
                     r_busy   <= 1'b1;
                     r_forced <= 1'b0;
                  end
               end
               PRE, WAIT_TRIG, POST: begin
                  if (w_strobe) begin
                     r_wr_en   <= 1'b1;
                     r_wr_addr <= r_ptr;
                     r_wr_data <= {{(RAM_W-ADC_W){1'b0}}, r_sample};
                     r_ptr     <= r_ptr + ADDR_W'(1);
                     if (r_state == PRE) begin
                        if (r_cnt == PRE_LAST) begin
                           r_state <= WAIT_TRIG;
                           r_cnt   <= '0;
                        end else begin
                           r_cnt <= r_cnt + ADDR_W'(1);
                        end
                     end else if (r_state == WAIT_TRIG) begin
                        if (w_trig) begin
                           r_state     <= POST;
                           r_trig_addr <= r_ptr;
                           r_forced    <= w_timed_out && !w_hit;
                           r_cnt       <= '0;
                        end
                     end else if (r_cnt == POST_LAST) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                     end else begin
                        r_cnt <= r_cnt + ADDR_W'(1);
                     end
                  end
               end
               DONE:    r_state <= IDLE;
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign wr_en     = r_wr_en;
   assign wr_addr   = r_wr_addr;
   assign wr_data   = r_wr_data;
   assign trig_addr = r_trig_addr;
   assign busy      = r_busy;
   assign done      = r_done;
   assign forced    = r_forced;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed self-checking bench for adc_capture_ctrl (TIMEOUT=100); the
// forced-trigger expectations follow the AUTO_TRIG_EN build setting.
module tb_adc_capture_ctrl;

   logic        sys_clk = 1'b0;
   logic        rst_n;
   logic [11:0] adc_data;
   logic        arm;
   logic        abort;
   logic [11:0] trig_level;
   logic        trig_rising;
   logic [7:0]  decim;
   logic        wr_en;
   logic [9:0]  wr_addr;
   logic [15:0] wr_data;
   logic [9:0]  trig_addr;
   logic        busy;
   logic        done;
   logic        forced;

   int total = 0;
   int bad   = 0;
   int n_wr;
   int n_done;
   int n_trig_at_done;

   always #5 sys_clk = ~sys_clk;

   adc_capture_ctrl #(
      .ADC_W(12), .ADDR_W(10), .PRE_DEPTH(256), .TIMEOUT(100)
   ) dut (
      .sys_clk     (sys_clk),
      .rst_n       (rst_n),
      .adc_data    (adc_data),
      .arm         (arm),
      .abort       (abort),
      .trig_level  (trig_level),
      .trig_rising (trig_rising),
      .decim       (decim),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .trig_addr   (trig_addr),
      .busy        (busy),
      .done        (done),
      .forced      (forced)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Outputs are sampled 1 time unit after the active edge.
   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   initial begin
      rst_n       = 1'b0;
      adc_data    = '0;
      arm         = 1'b0;
      abort       = 1'b0;
      trig_level  = 12'd2000;
      trig_rising = 1'b1;
      decim       = 8'd0;
      #12;
      check("rst_wr_en", wr_en, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_trig_addr", trig_addr, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_forced", forced, 0);
      rst_n = 1'b1;
      tick();
      tick();

      // Ramp, rising trigger at 2000 landing on the first WAIT_TRIG write.
      adc_data = 12'd1744;
      arm      = 1'b1;
      tick();
      arm    = 1'b0;
      n_wr   = 0;
      n_done = 0;
      for (int k = 1; k <= 1030; k++) begin
         adc_data = 12'(1744 + k);
         tick();
         if (k == 1) check("ramp_busy", busy, 1);
         if (wr_en) begin
            if (n_wr == 0) begin
               check("ramp_first_addr", wr_addr, 0);
               check("ramp_first_data", wr_data, 1744);
            end
            if (n_wr == 255) check("ramp_last_pre_data", wr_data, 1999);
            if (n_wr == 256) begin
               check("ramp_trig_wr_addr", wr_addr, 256);
               check("ramp_trig_wr_data", wr_data, 2000);
            end
            n_wr++;
         end
         if (done) begin
            n_done++;
            if (n_done == 1) begin
               check("ramp_done_nwr", n_wr, 1024);
               check("ramp_done_wr_en", wr_en, 1);
               check("ramp_done_addr", wr_addr, 1023);
               check("ramp_done_data", wr_data, 2767);
               check("ramp_done_busy", busy, 0);
               check("ramp_trig_addr", trig_addr, 256);
            end
         end
      end
      check("ramp_total_writes", n_wr, 1024);
      check("ramp_done_count", n_done, 1);
      check("ramp_idle_busy", busy, 0);
      check("ramp_forced", forced, 0);

      // Arm and abort in the same cycle: abort wins.
      arm   = 1'b1;
      abort = 1'b1;
      tick();
      arm   = 1'b0;
      abort = 1'b0;
      check("armabort_busy", busy, 0);
      n_wr = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (wr_en) n_wr++;
      end
      check("armabort_no_wr", n_wr, 0);

      // decim=3, flat input, with a second arm while busy that must be ignored.
      decim    = 8'd3;
      adc_data = 12'd500;
      arm      = 1'b1;
      tick();
      arm = 1'b0;
      check("d3_busy", busy, 1);
      n_done = 0;
      for (int k = 1; k <= 40; k++) begin
         arm = (k == 10);
         tick();
         check("d3_wr_en", wr_en, (k % 4) == 1);
         if ((k % 4) == 1) begin
            check("d3_wr_addr", wr_addr, (k - 1) / 4);
            check("d3_wr_data", wr_data, 500);
         end
         if (done) n_done++;
      end
      arm = 1'b0;
      check("d3_no_done", n_done, 0);
      check("d3_still_busy", busy, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("d3_abort_busy", busy, 0);

      // Falling trigger at 1000: step in PRE ignored, step in WAIT_TRIG taken.
      decim       = 8'd0;
      trig_level  = 12'd1000;
      trig_rising = 1'b0;
      adc_data    = 12'd1200;
      arm         = 1'b1;
      tick();
      arm = 1'b0;
      for (int k = 1; k <= 400; k++) begin
         adc_data = ((k >= 10 && k < 20) || k >= 300) ? 12'd800 : 12'd1200;
         tick();
         if (k == 11) check("fall_pre_step_data", wr_data, 800);
         if (k == 250) check("fall_pre_ignored", trig_addr, 256);
         if (k == 299) check("fall_wait_no_trig", trig_addr, 256);
         if (k == 301) begin
            check("fall_trig_wr_addr", wr_addr, 300);
            check("fall_trig_wr_data", wr_data, 800);
            check("fall_trig_addr", trig_addr, 300);
         end
      end

      // Abort mid-POST.
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_wr_en", wr_en, 0);
      check("abort_done", done, 0);
      n_wr   = 0;
      n_done = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (wr_en) n_wr++;
         if (done) n_done++;
      end
      check("abort_no_wr", n_wr, 0);
      check("abort_no_done", n_done, 0);
      check("abort_trig_hold", trig_addr, 300);

      // Re-arm restarts at address 0.
      arm = 1'b1;
      tick();
      arm = 1'b0;
      tick();
      check("rearm_wr_en", wr_en, 1);
      check("rearm_wr_addr", wr_addr, 0);
      abort = 1'b1;
      tick();
      abort = 1'b0;

      // Flat input that never crosses the level: timeout behaviour.
      trig_level  = 12'd2000;
      trig_rising = 1'b1;
      adc_data    = 12'd100;
      arm         = 1'b1;
      tick();
      arm = 1'b0;
      check("to_forced_cleared", forced, 0);
      n_wr   = 0;
      n_done = 0;
      n_trig_at_done = 0;
      for (int k = 1; k <= 1200; k++) begin
         tick();
         if (wr_en && n_done == 0) n_wr++;
         if (done) begin
            n_done++;
            n_trig_at_done = int'(trig_addr);
         end
      end
`ifdef AUTO_TRIG_EN
      check("to_done_count", n_done, 1);
      check("to_total_writes", n_wr, 1124);
      check("to_trig_addr", n_trig_at_done, 356);
      check("to_forced", forced, 1);
      arm = 1'b1;
      tick();
      arm = 1'b0;
      check("to_forced_rearm", forced, 0);
`else
      check("to_never_done", n_done, 0);
      check("to_forced_zero", forced, 0);
      check("to_still_busy", busy, 1);
`endif
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("final_idle", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
